// File: rtl/bfly_sdf_stage.sv
// Radix-2 DIF single-path-delay-feedback butterfly stage.
// A NUM_PAIR-deep delay line holds first-half samples, then the differences of the frame.
module bfly_sdf_stage #(
  parameter int WIDTH    = 12,
  parameter int NUM_PAIR = 16,
  parameter int SCALE    = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIDTH-1:0] din_re,
  input  logic [WIDTH-1:0] din_im,
  input  logic             flush,
  output logic             dout_valid,
  output logic [WIDTH:0]   dout_re,
  output logic [WIDTH:0]   dout_im,
  output logic             dout_diff,
  output logic             frame_done
);

  // state | meaning
  // FILL  | first half: store input, emit pending diffs of the previous frame
  // BFLY  | second half: emit a+b, store a-b
  // DRAIN | flush: emit stored diffs one per cycle, no input accepted
  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_BFLY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int CW = $clog2(NUM_PAIR);
  localparam int DW = WIDTH + 1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;

  logic [2*DW-1:0] mem [NUM_PAIR];

  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  logic signed [DW-1:0] w_re, w_im, o_re, o_im;
  logic                 o_vld, o_diff, o_fd, mem_we;
  logic                 drain_start, adv, wrap;

  assign drain_start = flush && (state_q == ST_FILL) && (cnt_q == '0) && pend_q;
  assign din_ready   = (state_q != ST_DRAIN) && !drain_start;
  assign adv         = (state_q == ST_DRAIN) || (din_valid && din_ready);
  assign wrap        = (cnt_q == CW'(NUM_PAIR - 1));

  // Depth equals the frame half, so the entry at cnt is always the oldest one.
  assign {a_re, a_im} = mem[cnt_q];
  assign b_re = {din_re[WIDTH-1], din_re};
  assign b_im = {din_im[WIDTH-1], din_im};

  function automatic logic [DW-1:0] scale_out(input logic signed [DW-1:0] x);
    logic [DW:0] t;
    t = {x[DW-1], x} + (DW + 1)'(1);
    if (SCALE != 0) return t[DW:1];
    else            return x;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    w_re    = b_re;
    w_im    = b_im;
    o_re    = '0;
    o_im    = '0;
    o_vld   = 1'b0;
    o_diff  = 1'b0;
    o_fd    = 1'b0;
    mem_we  = 1'b0;
    if (adv) begin
      cnt_d = cnt_q + 1'b1;
      case (state_q)
        ST_FILL: begin
          mem_we = 1'b1;
          if (pend_q) begin
            o_vld  = 1'b1;
            o_diff = 1'b1;
            o_fd   = wrap;
            o_re   = a_re;
            o_im   = a_im;
          end
          if (wrap) begin
            pend_d  = 1'b0;
            state_d = ST_BFLY;
          end
        end
        ST_BFLY: begin
          mem_we = 1'b1;
          w_re   = a_re - b_re;
          w_im   = a_im - b_im;
          o_vld  = 1'b1;
          o_re   = a_re + b_re;
          o_im   = a_im + b_im;
          if (wrap) begin
            pend_d  = 1'b1;
            state_d = ST_FILL;
          end
        end
        ST_DRAIN: begin
          o_vld  = 1'b1;
          o_diff = 1'b1;
          o_fd   = wrap;
          o_re   = a_re;
          o_im   = a_im;
          if (wrap) begin
            pend_d  = 1'b0;
            state_d = ST_FILL;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end else if (drain_start) begin
      state_d = ST_DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      dout_valid <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
      dout_diff  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      dout_valid <= o_vld;
      dout_re    <= o_vld ? scale_out(o_re) : '0;
      dout_im    <= o_vld ? scale_out(o_im) : '0;
      dout_diff  <= o_diff;
      frame_done <= o_fd;
    end
  end

  // Contents are never emitted before being written in the current frame sequence.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cnt_q] <= {w_re, w_im};
  end

endmodule

// File: tb/tb_bfly_sdf_stage.sv
// Bench for bfly_sdf_stage: two instances (SCALE=0/1) share stimulus and are
// checked against a frame-level sum/difference model.
module tb_bfly_sdf_stage;
  localparam int W = 12;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic din_valid = 1'b0;
  logic flush = 1'b0;
  logic [W-1:0] din_re = '0;
  logic [W-1:0] din_im = '0;
  logic din_ready0, din_ready1, dv0, dv1, dd0, dd1, fd0, fd1;
  logic signed [W:0] dre0, dim0, dre1, dim1;

  always #5 clk = ~clk;

  bfly_sdf_stage #(.WIDTH(W), .NUM_PAIR(N), .SCALE(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_ready(din_ready0),
    .din_re(din_re), .din_im(din_im), .flush(flush), .dout_valid(dv0),
    .dout_re(dre0), .dout_im(dim0), .dout_diff(dd0), .frame_done(fd0));

  bfly_sdf_stage #(.WIDTH(W), .NUM_PAIR(N), .SCALE(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_ready(din_ready1),
    .din_re(din_re), .din_im(din_im), .flush(flush), .dout_valid(dv1),
    .dout_re(dre1), .dout_im(dim1), .dout_diff(dd1), .frame_done(fd1));

  typedef struct {int re; int im; bit diff; bit fd;} exp_t;
  exp_t exp_q[$];
  int fr_re[2*N];
  int fr_im[2*N];
  int idx = 0;
  int n_checks = 0;
  int n_fail = 0;
  int out_cnt = 0;
  bit prev_acc = 1'b0;
  bit expect_drain = 1'b0;

  function automatic int sc(input int x);
    return (x + 1) >>> 1;
  endfunction

  // Reference: sum k appears once x[k+N] is taken; the frame's diffs follow in order.
  always @(posedge clk) begin
    prev_acc <= rstn && din_valid && din_ready0;
    if (rstn && din_valid && din_ready0) begin
      fr_re[idx] = int'($signed(din_re));
      fr_im[idx] = int'($signed(din_im));
      if (idx >= N)
        exp_q.push_back('{fr_re[idx-N] + fr_re[idx], fr_im[idx-N] + fr_im[idx], 1'b0, 1'b0});
      idx++;
      if (idx == 2*N) begin
        for (int k = 0; k < N; k++)
          exp_q.push_back('{fr_re[k] - fr_re[k+N], fr_im[k] - fr_im[k+N], 1'b1, k == N-1});
        idx = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    n_checks++;
    if (dv0) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got re=%0d im=%0d diff=%0b, required no output", dre0, dim0, dd0);
      end else begin
        e = exp_q.pop_front();
        if (dre0 !== e.re || dim0 !== e.im || dd0 !== e.diff || fd0 !== e.fd) begin
          n_fail++;
          $display("FAIL out_full: got re=%0d im=%0d diff=%0b fd=%0b, required re=%0d im=%0d diff=%0b fd=%0b",
                   dre0, dim0, dd0, fd0, e.re, e.im, e.diff, e.fd);
        end
        n_checks++;
        if (dv1 !== 1'b1 || dre1 !== sc(e.re) || dim1 !== sc(e.im) || dd1 !== e.diff || fd1 !== e.fd) begin
          n_fail++;
          $display("FAIL out_scaled: got v=%0b re=%0d im=%0d diff=%0b fd=%0b, required v=1 re=%0d im=%0d diff=%0b fd=%0b",
                   dv1, dre1, dim1, dd1, fd1, sc(e.re), sc(e.im), e.diff, e.fd);
        end
      end
      n_checks++;
      if (!prev_acc && !expect_drain) begin
        n_fail++;
        $display("FAIL out_timing: got dout_valid=1 without preceding accept or drain, required 0");
      end
    end else if (dre0 !== 0 || dim0 !== 0 || dd0 !== 0 || fd0 !== 0 ||
                 dv1 !== 0 || dre1 !== 0 || dim1 !== 0 || fd1 !== 0) begin
      n_fail++;
      $display("FAIL idle_zero: got re=%0d im=%0d diff=%0b fd=%0b v1=%0b, required all 0",
               dre0, dim0, dd0, fd0, dv1);
    end
  end

  task automatic model_clear();
    idx = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_valid = 1'b0;
    flush = 1'b0;
    #2;
    rstn = 1'b0;
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drive(input int re, input int im, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        din_valid = 1'b0;
      end
    end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din_re = W'(re);
      din_im = W'(im);
      #1;
      if (din_ready0) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL drive_timeout: got din_ready=0 for 20 cycles, required 1");
  endtask

  task automatic do_flush();
    @(negedge clk);
    din_valid = 1'b0;
    flush = 1'b1;
    expect_drain = 1'b1;
    #1;
    n_checks++;
    if (din_ready0 !== 1'b0 || din_ready1 !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: got din_ready=%0b, required 0", din_ready0);
    end
    @(negedge clk);
    flush = 1'b0;
    for (int t = 0; t < N + 4; t++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    @(negedge clk);
    #2;
    expect_drain = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL flush_drain: got %0d outputs outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (dv0 !== 0 || dre0 !== 0 || dim0 !== 0 || dd0 !== 0 || fd0 !== 0 || din_ready0 !== 1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b re=%0d im=%0d diff=%0b fd=%0b rdy=%0b, required 0/0/0/0/0/1",
               dv0, dre0, dim0, dd0, fd0, din_ready0);
    end
    @(negedge clk);
    rstn = 1'b1;
    flush = 1'b1;
    #1;
    n_checks++;
    if (din_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ignored: got din_ready=%0b, required 1", din_ready0);
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_basic();
    int c0;
    do_reset();
    c0 = out_cnt;
    for (int i = 1; i <= 8; i++) drive(i, 0, 1'b0);
    do_flush();
    n_checks++;
    if (out_cnt - c0 != 8) begin
      n_fail++;
      $display("FAIL basic_count: got %0d outputs, required 8", out_cnt - c0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i > N) begin
        n_checks++;
        if (dv0 !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_valid: got dout_valid=%0b at step %0d, required 1", dv0, i);
        end
      end
      din_valid = 1'b1;
      din_re = W'((i < 8) ? i + 1 : i + 3);
      din_im = '0;
      #1;
      n_checks++;
      if (din_ready0 !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready: got din_ready=%0b at step %0d, required 1", din_ready0, i);
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
    n_checks++;
    if (dv0 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_valid_last: got dout_valid=%0b, required 1", dv0);
    end
    do_flush();
  endtask

  task automatic test_extremes();
    int xr[8] = '{2047, -2048, 1, -1, 2047, 2047, 2, -2};
    int xi[8] = '{-2048, 2047, 1, -1, 2047, 2047, 2, -2};
    do_reset();
    for (int i = 0; i < 8; i++) drive(xr[i], xi[i], 1'b0);
    do_flush();
  endtask

  task automatic test_gaps();
    int c0;
    do_reset();
    c0 = out_cnt;
    for (int i = 1; i <= 8; i++) drive(i, 0, 1'b1);
    do_flush();
    n_checks++;
    if (out_cnt - c0 != 8) begin
      n_fail++;
      $display("FAIL gaps_count: got %0d outputs, required 8", out_cnt - c0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3 * 2 * N; i++)
      drive(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 1'b1);
    do_flush();
  endtask

  task automatic test_flush_collision();
    do_reset();
    for (int i = 1; i <= 8; i++) drive(i * 3, -i, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    din_valid = 1'b1;
    din_re = W'(99);
    expect_drain = 1'b1;
    #1;
    n_checks++;
    if (din_ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_ready: got din_ready=%0b, required 0", din_ready0);
    end
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      flush = 1'b0;
      #1;
      n_checks++;
      if (din_ready0 !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_ready: got din_ready=%0b at drain cycle %0d, required 0", din_ready0, i);
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
    #2;
    expect_drain = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || idx != 0) begin
      n_fail++;
      $display("FAIL collide_drain: got %0d outstanding, idx=%0d, required 0/0", exp_q.size(), idx);
    end
  endtask

  task automatic test_reset_mid_bfly();
    do_reset();
    for (int i = 1; i <= 8; i++) drive(i, 2 * i, 1'b0);
    for (int i = 11; i <= 16; i++) drive(i, -i, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    #2;
    rstn = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (dv0 !== 0 || dre0 !== 0 || dim0 !== 0 || dd0 !== 0 || din_ready0 !== 1) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%0b re=%0d im=%0d diff=%0b rdy=%0b, required 0/0/0/0/1",
               dv0, dre0, dim0, dd0, din_ready0);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 21; i <= 28; i++) drive(i, 30 - i, 1'b0);
    do_flush();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_extremes();
    test_gaps();
    test_random();
    test_flush_collision();
    test_reset_mid_bfly();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
